// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings and types for the issue scoreboard: register-file codes,
// 6-bit register id {is_fpr, index}, and the longest result latency.
package issue_scoreboard_pkg;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_GPR  = 2'b01;
   localparam logic [1:0] RW_FPR  = 2'b10;

   localparam logic [4:0] WAIT_LONG = 5'd31;
   localparam int         CNT_W     = $bits(WAIT_LONG);
   localparam int         NUM_REGS  = 64;

   typedef logic [5:0]       reg_id_t;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic reg_id_t mk_id(input logic [1:0] rw, input logic [4:0] idx);
      return {rw == RW_FPR, idx};
   endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown entry: issue load beats writeback clear, which
// beats the free-running decrement toward zero.
module sb_entry
   import issue_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  cnt_t load_val_i,
   input  logic clr_i,
   output cnt_t cnt_o,
   output logic nz_next_o
);

   cnt_t cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (clr_i)
         cnt_d = '0;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o     = cnt_q;
   assign nz_next_o = (cnt_d != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register result countdowns plus a shared
// long-latency unit tracker. Build option SCOREBOARD_FWD_EN lets a source be
// consumed on the result's final cycle through the forwarding path.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [5:0] id_rs,
   input  logic       id_use_s,
   input  logic [5:0] id_rt,
   input  logic       id_use_t,
   input  logic [1:0] id_rw,
   input  logic [4:0] id_rd,
   input  logic [4:0] id_wait_time,
   input  logic       id_long,
   input  logic       flush,
   input  logic [1:0] wb_rw,
   input  logic [4:0] wb_rd,
   output logic       issue,
   output logic       stall,
   output logic       long_busy,
   output logic       busy_any
);

   cnt_t    cnt     [NUM_REGS];
   logic    nz_next [NUM_REGS];
   reg_id_t dst_id, wb_id;
   logic    wr_en, wb_en;
   logic    rs_ok, rt_ok, waw, struct_haz;
   cnt_t    long_cnt_q, long_cnt_d;
   logic    busy_any_q, busy_any_d;

   assign dst_id = mk_id(id_rw, id_rd);
   assign wb_id  = mk_id(wb_rw, wb_rd);
   assign wr_en  = issue && (id_rw != RW_NONE);
   assign wb_en  = (wb_rw != RW_NONE);

   // GPR $zero has no storage; it reads as permanently ready.
   assign cnt[0]     = '0;
   assign nz_next[0] = 1'b0;

   genvar gi;
   for (gi = 1; gi < NUM_REGS; gi++) begin : g_ent
      sb_entry u_ent (
         .clk        (clk),
         .rst        (rst),
         .load_i     (wr_en && (dst_id == reg_id_t'(gi))),
         .load_val_i (id_wait_time),
         .clr_i      (wb_en && (wb_id == reg_id_t'(gi))),
         .cnt_o      (cnt[gi]),
         .nz_next_o  (nz_next[gi])
      );
   end

`ifdef SCOREBOARD_FWD_EN
   assign rs_ok = !id_use_s || (id_rs == '0) || (cnt[id_rs] <= cnt_t'(1));
   assign rt_ok = !id_use_t || (id_rt == '0) || (cnt[id_rt] <= cnt_t'(1));
`else
   assign rs_ok = !id_use_s || (id_rs == '0) || (cnt[id_rs] == '0);
   assign rt_ok = !id_use_t || (id_rt == '0) || (cnt[id_rt] == '0);
`endif

   assign waw        = (id_rw != RW_NONE) && (cnt[dst_id] > id_wait_time);
   assign long_busy  = (long_cnt_q > cnt_t'(1));
   assign struct_haz = id_long && long_busy;

   assign stall = id_valid && (!rs_ok || !rt_ok || waw || struct_haz);
   assign issue = id_valid && !stall && !flush;

   always_comb begin
      long_cnt_d = long_cnt_q;
      if (issue && id_long)
         long_cnt_d = id_wait_time;
      else if (long_cnt_q != '0)
         long_cnt_d = long_cnt_q - 1'b1;
   end

   always_comb begin
      busy_any_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         busy_any_d = busy_any_d | nz_next[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         long_cnt_q <= '0;
         busy_any_q <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         busy_any_q <= busy_any_d;
      end
   end

   assign busy_any = busy_any_q;

endmodule
